// File: rtl/fp2fix_conv_scheduler_if.sv
// fp2fix_conv_scheduler_if: requester, response and converter bus of the shared float-to-fixed scheduler
interface fp2fix_conv_scheduler_if #(parameter int N_REQ = 4);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_float;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [64:0]         rsp_fixed;
  logic [4:0]          rsp_flags;
  logic                rsp_timeout;
  logic [31:0]         conv_float;
  logic                conv_reset;
  logic [64:0]         conv_fixed;
  logic [4:0]          conv_flags;
  logic                conv_done;
  logic                busy;
  modport master (
    output req_valid, req_float, rsp_ready, conv_fixed, conv_flags, conv_done,
    input  req_ready, rsp_valid, rsp_id, rsp_fixed, rsp_flags, rsp_timeout, conv_float, conv_reset, busy
  );
  modport slave (
    input  req_valid, req_float, rsp_ready, conv_fixed, conv_flags, conv_done,
    output req_ready, rsp_valid, rsp_id, rsp_fixed, rsp_flags, rsp_timeout, conv_float, conv_reset, busy
  );
endinterface

// File: rtl/fp2fix_conv_scheduler.sv
// fp2fix_conv_scheduler: round-robin sharing of one float-to-32.32-fixed converter among N_REQ requesters
module fp2fix_conv_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  fp2fix_conv_scheduler_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;
  state_t        r_state, w_next;
  logic [IW-1:0] r_rr_ptr, r_rsp_id, w_grant, w_idx;
  logic          w_any, w_tmo, w_accept, w_finish;
  logic [31:0]   r_conv_float;
  logic [64:0]   r_rsp_fixed;
  logic [4:0]    r_rsp_flags;
  logic          r_rsp_timeout;
  logic [CW-1:0] r_cnt;
  // scan from the highest offset down so the nearest requester after rr_ptr wins
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = IW'((32'(r_rr_ptr) + 32'(k)) % 32'(N_REQ));
      if (bus.req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end
  assign w_tmo    = r_cnt == CW'(TIMEOUT - 1);
  assign w_accept = r_state == IDLE && w_any;
  assign w_finish = r_state == WAIT && (bus.conv_done || w_tmo);
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE ? (w_any ? LOAD : IDLE)
           : r_state == LOAD ? WAIT
           : r_state == WAIT ? (w_finish ? RESP : WAIT)
           : (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr      <= '0;
      r_rsp_id      <= '0;
      r_conv_float  <= '0;
      r_rsp_fixed   <= '0;
      r_rsp_flags   <= '0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      if (w_accept) begin
        r_conv_float <= bus.req_float[32*w_grant +: 32];
        r_rsp_id     <= w_grant;
        r_rr_ptr     <= w_grant == IW'(N_REQ - 1) ? '0 : w_grant + 1'b1;
      end
      r_cnt <= r_state == WAIT ? r_cnt + 1'b1 : '0;
      // done has priority over an expiring counter in the same cycle
      if (w_finish) begin
        r_rsp_fixed   <= bus.conv_done ? bus.conv_fixed : '0;
        r_rsp_flags   <= bus.conv_done ? bus.conv_flags : '0;
        r_rsp_timeout <= !bus.conv_done;
      end
    end
  end
  assign bus.req_ready   = w_accept ? N_REQ'(1) << w_grant : '0;
  assign bus.rsp_valid   = r_state == RESP;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_fixed   = r_rsp_fixed;
  assign bus.rsp_flags   = r_rsp_flags;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.conv_float  = r_conv_float;
  assign bus.conv_reset  = reset || r_state == LOAD;
  assign bus.busy        = r_state != IDLE;
endmodule

// File: tb/tb_fp2fix_conv_scheduler.sv
// tb_fp2fix_conv_scheduler: directed plus randomized jobs checked against a job-level reference model
module tb_fp2fix_conv_scheduler;
  localparam int N  = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0, m_rr = 0, cfg_lat = 0, m_cnt = 100;
  always #5 clk = ~clk;
  fp2fix_conv_scheduler_if #(.N_REQ(N)) bus();
  fp2fix_conv_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [69:0] conv(input logic [31:0] f);
    int x;
    logic [63:0] mag;
    x = int'(f[30:23]) - 127;
    if (f[30:23] == 8'hFF) return f[22:0] != 0 ? {5'b00001, 65'd0} : {f[31] ? 5'b00100 : 5'b00010, 65'd0};
    if (f[30:23] == 8'h00) return {f[22:0] != 0 ? 5'b10000 : 5'b00000, 65'd0};
    if (x > 31) return {5'b01000, 65'd0};
    mag = {40'd0, 1'b1, f[22:0]};
    mag = x + 9 >= 0 ? mag << (x + 9) : mag >> (-(x + 9));
    return {mag == 0 ? 5'b10000 : 5'b00000, f[31], mag};
  endfunction
  // converter model: done rises cfg_lat cycles after its reset drops, never when cfg_lat < 0
  always @(posedge clk) m_cnt <= bus.conv_reset ? 0 : (m_cnt < 1000 ? m_cnt + 1 : m_cnt);
  assign bus.conv_done = cfg_lat >= 0 && m_cnt >= cfg_lat;
  assign {bus.conv_flags, bus.conv_fixed} = conv(bus.conv_float);
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction
  function automatic logic [31:0] rnd_float();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h7FC00000 | 32'($urandom_range(0, 255));
    if (r == 1) return $urandom_range(0, 1) != 0 ? 32'hFF800000 : 32'h7F800000;
    if (r == 2) return {1'($urandom_range(0, 1)), 8'($urandom_range(160, 254)), 23'($urandom)};
    return {1'($urandom_range(0, 1)), 8'($urandom_range(90, 158)), 23'($urandom)};
  endfunction
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
    chk({tag, "_rsp_fixed"}, bus.rsp_fixed, 0);
    chk({tag, "_rsp_flags"}, bus.rsp_flags, 0);
    chk({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
    chk({tag, "_conv_float"}, bus.conv_float, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_conv_reset"}, bus.conv_reset, 1);
  endtask
  // one complete job: accept, convert (or time out), respond with optional stall
  task automatic serve(input int lat, input int stall, input bit drop, output int rid,
                       output logic [64:0] fx, output logic [4:0] fl, output logic to, output int aw);
    int g, lc, nrst, bad, elat;
    logic [N-1:0] eg;
    logic [31:0] ef;
    logic [69:0] er;
    cfg_lat = lat;
    #1;
    aw = 0;
    while (bus.req_ready == 0 && aw < 30) begin
      cyc();
      aw++;
    end
    g = pick(bus.req_valid);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("grant", bus.req_ready, eg);
    rid = -1; fx = '0; fl = '0; to = 1'b0;
    if (g < 0 || bus.req_ready == 0) return;
    m_rr = (g + 1) % N;
    ef = bus.req_float[g*32 +: 32];
    er = lat < 0 ? 70'd0 : conv(ef);
    elat = lat >= 0 ? 3 + lat : 2 + TO;
    lc = 0; nrst = 0; bad = 0;
    while (!bus.rsp_valid && lc < 40) begin
      cyc();
      lc++;
      if (drop && lc == 1) bus.req_valid[g] = 1'b0;
      nrst += int'(bus.conv_reset);
      if (bus.req_ready != 0 || (!bus.rsp_valid && bus.conv_float != ef)) bad++;
    end
    chk("latency", lc, elat);
    chk("conv_reset_pulses", nrst, 1);
    chk("busy_phase_stable", bad, 0);
    chk("rsp_id", bus.rsp_id, g);
    chk("rsp_fixed", bus.rsp_fixed, er[64:0]);
    chk("rsp_flags", bus.rsp_flags, er[69:65]);
    chk("rsp_timeout", bus.rsp_timeout, lat < 0);
    rid = int'(bus.rsp_id); fx = bus.rsp_fixed; fl = bus.rsp_flags; to = bus.rsp_timeout;
    bad = 0;
    for (int s = 0; s < stall; s++) begin
      cyc();
      if (!bus.rsp_valid || bus.rsp_fixed !== fx || bus.rsp_flags !== fl || bus.rsp_timeout !== to
          || int'(bus.rsp_id) != rid || bus.req_ready != 0) bad++;
    end
    chk("stall_stable", bad, 0);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus.rsp_valid, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int rid, aw, n, lat;
    int rr1[5];
    logic [64:0] fx;
    logic [4:0] fl;
    logic to;
    rr1 = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_float = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) cyc();
    chk_reset("init");
    reset = 1'b0;
    cyc();
    chk("idle_conv_reset", bus.conv_reset, 0);
    // single request converting 1.0
    bus.req_float[63:32] = 32'h3F800000;
    bus.req_valid = 4'b0010;
    serve(0, 0, 1, rid, fx, fl, to, aw);
    chk("one_id", rid, 1);
    chk("one_fixed", fx, 65'h0_00000001_00000000);
    chk("one_flags", fl, 0);
    chk("one_timeout", to, 0);
    // reset while waiting on the converter drops the job
    bus.req_float[31:0] = 32'h3F800000;
    bus.req_valid = 4'b0001;
    cfg_lat = -1;
    #1;
    chk("rst_accept", bus.req_ready, 1);
    repeat (3) cyc();
    chk("rst_busy_in_wait", bus.busy, 1);
    bus.req_valid = '0;
    reset = 1'b1;
    #1;
    chk("rst_conv_reset", bus.conv_reset, 1);
    cyc();
    chk_reset("midwait");
    reset = 1'b0;
    m_rr = 0;
    n = 0;
    repeat (6) begin
      cyc();
      n += int'(bus.rsp_valid | bus.busy);
    end
    chk("no_rsp_after_rst", n, 0);
    // round robin with all requesters held
    for (int i = 0; i < N; i++) bus.req_float[i*32 +: 32] = rnd_float();
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      serve($urandom_range(0, 3), 0, 0, rid, fx, fl, to, aw);
      chk("rr_all_order", rid, rr1[j]);
    end
    bus.req_valid = 4'b0101;
    serve(1, 0, 1, rid, fx, fl, to, aw);
    chk("rr_pair_first", rid, 2);
    serve(1, 0, 1, rid, fx, fl, to, aw);
    chk("rr_pair_second", rid, 0);
    // flag pass-through
    bus.req_float[31:0] = 32'h7FC00000;
    bus.req_valid = 4'b0001;
    serve(0, 0, 1, rid, fx, fl, to, aw);
    chk("nan_flags", fl, 5'b00001);
    bus.req_float[31:0] = 32'hFF800000;
    bus.req_valid = 4'b0001;
    serve(1, 0, 1, rid, fx, fl, to, aw);
    chk("neginf_flags", fl, 5'b00100);
    bus.req_float[31:0] = 32'h7F7FFFFF;
    bus.req_valid = 4'b0001;
    serve(2, 0, 1, rid, fx, fl, to, aw);
    chk("overflow_flags", fl, 5'b01000);
    // done on the last WAIT cycle beats the timeout
    bus.req_float[31:0] = 32'h3F800000;
    bus.req_valid = 4'b0001;
    serve(TO - 1, 0, 1, rid, fx, fl, to, aw);
    chk("edge_timeout", to, 0);
    chk("edge_fixed", fx, 65'h0_00000001_00000000);
    // converter never finishes
    bus.req_valid = 4'b0001;
    serve(-1, 0, 1, rid, fx, fl, to, aw);
    chk("timeout_flag", to, 1);
    chk("timeout_fixed", fx, 0);
    // stale done left high from the last conversion must be ignored in LOAD
    bus.req_float[31:0] = 32'h40490FDB;
    bus.req_valid = 4'b0001;
    serve(2, 0, 1, rid, fx, fl, to, aw);
    chk("stale_id", rid, 0);
    // response backpressure with requester 3 waiting
    bus.req_float[63:32] = rnd_float();
    bus.req_float[127:96] = rnd_float();
    bus.req_valid = 4'b1010;
    serve(0, 10, 1, rid, fx, fl, to, aw);
    chk("bp_first", rid, 1);
    serve(0, 0, 1, rid, fx, fl, to, aw);
    chk("bp_pending_id", rid, 3);
    chk("bp_accept_wait", aw, 0);
    // randomized traffic
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 1) != 0) begin
          bus.req_float[i*32 +: 32] = rnd_float();
          bus.req_valid[i] = 1'b1;
        end
      if (bus.req_valid == 0) begin
        bus.req_float[31:0] = rnd_float();
        bus.req_valid[0] = 1'b1;
      end
      lat = $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(0, TO - 1));
      serve(lat, $urandom_range(0, 3), 1, rid, fx, fl, to, aw);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
